// File: rtl/alu_int_div.sv
// rtl/alu_int_div.sv - iterative radix-2 restoring 32-bit divider (DIV/DIVU/REM/REMU), optional ALU_INT_DIV_EARLY_OUT_EN
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module alu_int_div #(
  parameter int IDX_W = `PRF_INT_INDEX_SIZE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  input  logic [IDX_W-1:0] in_rd_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_rd_index,
  output logic [31:0]      out_rd_data
);

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic finalize;

  // latched operation context
  logic             op_rem;
  logic             neg_quo;
  logic             neg_rem;
  logic             div_zero;
  logic             overflow;
  logic [XLEN-1:0]  dividend_raw;
  logic [XLEN-1:0]  divisor_mag;
  logic [XLEN-1:0]  dvd;
  logic [XLEN-1:0]  rem;
  logic [5:0]       count;
  logic [IDX_W-1:0] rd_index;

  // operand decode on the input side
  logic            in_signed;
  logic            in_sign1;
  logic            in_sign2;
  logic [XLEN-1:0] in_mag1;
  logic [XLEN-1:0] in_mag2;
  logic            in_div_zero;
  logic            in_overflow;
  logic            in_special;

  // one restoring step
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            q_bit;

  // sign-corrected result
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] result;

  // RISC-V defined results for divide-by-zero and signed overflow
  function automatic logic [XLEN-1:0] special_result(input logic want_rem, input logic dz,
                                                     input logic [XLEN-1:0] dividend);
    logic [XLEN-1:0] r;
    if (dz) r = want_rem ? dividend : {XLEN{1'b1}};
    else    r = want_rem ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    return r;
  endfunction

  // decode signs, magnitudes and special cases of the offered operands
  always_comb begin
    in_signed   = ~in_op[0];
    in_sign1    = in_signed & in_rs1_data[XLEN-1];
    in_sign2    = in_signed & in_rs2_data[XLEN-1];
    in_mag1     = in_sign1 ? (~in_rs1_data + 1'b1) : in_rs1_data;
    in_mag2     = in_sign2 ? (~in_rs2_data + 1'b1) : in_rs2_data;
    in_div_zero = (in_rs2_data == '0);
    in_overflow = in_signed & (in_rs1_data == 32'h8000_0000) & (in_rs2_data == 32'hFFFF_FFFF);
    in_special  = in_div_zero | in_overflow;
  end

  // restoring step: shift in next dividend bit, subtract divisor if it fits
  always_comb begin
    rem_shift = {rem, dvd[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor_mag};
    q_bit     = ~diff[XLEN];
  end

  // final sign correction and special-case mux
  always_comb begin
    quo_fix = neg_quo ? (~dvd + 1'b1) : dvd;
    rem_fix = neg_rem ? (~rem + 1'b1) : rem;
    if (div_zero || overflow) result = special_result(op_rem, div_zero, dividend_raw);
    else                      result = op_rem ? rem_fix : quo_fix;
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state and handshake outputs; flush overrides everything
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    finalize   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept = 1'b1;
`ifdef ALU_INT_DIV_EARLY_OUT_EN
          state_next = in_special ? DONE : BUSY;
`else
          state_next = BUSY;
`endif
        end
      end
      BUSY: begin
        if (count == 6'd32) begin
          finalize   = ~flush;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // datapath: latch on accept, iterate in BUSY, register result on finalize
  always_ff @(posedge clock) begin
    if (reset) begin
      op_rem       <= 1'b0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      overflow     <= 1'b0;
      dividend_raw <= '0;
      divisor_mag  <= '0;
      dvd          <= '0;
      rem          <= '0;
      count        <= '0;
      rd_index     <= '0;
      out_rd_data  <= '0;
      out_rd_index <= '0;
    end else if (accept) begin
      op_rem       <= in_op[1];
      neg_quo      <= in_sign1 ^ in_sign2;
      neg_rem      <= in_sign1;
      div_zero     <= in_div_zero;
      overflow     <= in_overflow;
      dividend_raw <= in_rs1_data;
      divisor_mag  <= in_mag2;
      dvd          <= in_mag1;
      rem          <= '0;
      count        <= '0;
      rd_index     <= in_rd_index;
`ifdef ALU_INT_DIV_EARLY_OUT_EN
      if (in_special) begin
        out_rd_data  <= special_result(in_op[1], in_div_zero, in_rs1_data);
        out_rd_index <= in_rd_index;
      end
`endif
    end else if (finalize) begin
      out_rd_data  <= result;
      out_rd_index <= rd_index;
    end else if (state == BUSY && count != 6'd32) begin
      rem   <= q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      dvd   <= {dvd[XLEN-2:0], q_bit};
      count <= count + 6'd1;
    end
  end

endmodule

// File: tb/tb_alu_int_div.sv
// tb/tb_alu_int_div.sv - directed self-checking bench for alu_int_div
`timescale 1ns/1ps

module tb_alu_int_div;

  localparam int IDX_W = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'd0;
  logic [31:0]      in_rs1_data = '0;
  logic [31:0]      in_rs2_data = '0;
  logic [IDX_W-1:0] in_rd_index = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_rd_index;
  logic [31:0]      out_rd_data;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  alu_int_div #(.IDX_W(IDX_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd_index(in_rd_index),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_index(out_rd_index), .out_rd_data(out_rd_data)
  );

  always #5 clock = ~clock;

  function automatic int exp_lat(input bit special);
`ifdef ALU_INT_DIV_EARLY_OUT_EN
    return special ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // offer one op from IDLE, wait for result with out_ready low, then retire it
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [IDX_W-1:0] idx, output logic [31:0] data,
                        output logic [IDX_W-1:0] ridx, output int lat);
    in_op = op; in_rs1_data = a; in_rs2_data = b; in_rd_index = idx;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!out_valid && lat < 100);
    data = out_rd_data;
    ridx = out_rd_index;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%h want=0", out_rd_data); end
    checks++; if (out_rd_index !== '0) begin failures++; $display("FAIL reset_rd_index got=%h want=0", out_rd_index); end
  endtask

  task automatic test_vectors();
    logic [1:0]  ops [14] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIV,
                              OP_DIV, OP_REMU, OP_DIV, OP_REM, OP_REM, OP_DIVU};
    logic [31:0] as  [14] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
                              32'd20, 32'd20, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFFB, 32'h8000_0000};
    logic [31:0] bs  [14] = '{32'd7, 32'd7, 32'd1, 32'h10, 32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] exp [14] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'hF, 32'hFFFF_FFFA, 32'hFFFF_FFFE,
                              32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                              32'hFFFF_FFFB, 32'd0};
    bit          spc [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [31:0]      data;
    logic [IDX_W-1:0] ridx;
    int               lat;
    for (int i = 0; i < 14; i++) begin
      run_op(ops[i], as[i], bs[i], IDX_W'(i + 3), data, ridx, lat);
      checks++; if (data !== exp[i]) begin failures++; $display("FAIL vec%0d_data got=%h want=%h", i, data, exp[i]); end
      checks++; if (ridx !== IDX_W'(i + 3)) begin failures++; $display("FAIL vec%0d_index got=%h want=%h", i, ridx, IDX_W'(i + 3)); end
      checks++; if (lat !== exp_lat(spc[i])) begin failures++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, exp_lat(spc[i])); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_retire got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int  cyc;
    bit  bad_busy;
    bit  bad_hold;
    bit  leaked;
    in_op = OP_DIVU; in_rs1_data = 32'd100; in_rs2_data = 32'd7; in_rd_index = 7'd5;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    in_op = OP_DIVU; in_rs1_data = 32'd50; in_rs2_data = 32'd5; in_rd_index = 7'd44;
    bad_busy = 0; cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready !== 1'b0) bad_busy = 1;
      @(posedge clock); #1; cyc++;
    end
    checks++; if (bad_busy || cyc != 33) begin failures++; $display("FAIL bp_busy in_ready_seen_high=%0d cycles=%0d want=33", bad_busy, cyc); end
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_rd_data !== 32'd14 || out_rd_index !== 7'd5 || in_ready !== 1'b0) bad_hold = 1;
      @(posedge clock); #1;
    end
    checks++; if (bad_hold) begin failures++; $display("FAIL bp_hold got=v%b d=%h i=%h r=%b want=v1 d=0000000e i=05 r=0", out_valid, out_rd_data, out_rd_index, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    leaked = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) leaked = 1;
      @(posedge clock); #1;
    end
    checks++; if (leaked) begin failures++; $display("FAIL bp_ignored_offer got=v%b r%b want=v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_flush();
    logic [31:0]      data;
    logic [IDX_W-1:0] ridx;
    int               lat;
    bit               seen;
    in_op = OP_DIVU; in_rs1_data = 32'd1000; in_rs2_data = 32'd10; in_rd_index = 7'd9;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIVU; in_rs1_data = 32'd8; in_rs2_data = 32'd2; in_rd_index = 7'd60;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got=r%b v%b want=r1 v0", in_ready, out_valid); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen = 1;
      @(posedge clock); #1;
    end
    checks++; if (seen) begin failures++; $display("FAIL flush_no_result got=1 want=0"); end
    run_op(OP_DIVU, 32'd9, 32'd3, 7'd12, data, ridx, lat);
    checks++; if (data !== 32'd3 || ridx !== 7'd12) begin failures++; $display("FAIL flush_next_op got=%h/%h want=00000003/0c", data, ridx); end
  endtask

  task automatic test_reset_mid();
    in_op = OP_DIVU; in_rs1_data = 32'd77; in_rs2_data = 32'd7; in_rd_index = 7'd33;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_handshake got=v%b r%b want=v0 r1", out_valid, in_ready); end
    checks++; if (out_rd_data !== 32'd0 || out_rd_index !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h/%h want=0/0", out_rd_data, out_rd_index); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    in_op = OP_DIVU; in_rs1_data = 32'd42; in_rs2_data = 32'd6; in_rd_index = 7'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_op = OP_REMU; in_rs1_data = 32'd43; in_rs2_data = 32'd6; in_rd_index = 7'd2;
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
    checks++; if (out_rd_data !== 32'd7 || out_rd_index !== 7'd1) begin failures++; $display("FAIL b2b_first got=%h/%h want=00000007/01", out_rd_data, out_rd_index); end
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap got=v%b r%b want=v0 r1", out_valid, in_ready); end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b want=0", in_ready); end
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clock); #1; cyc++; end
    checks++; if (out_rd_data !== 32'd1 || out_rd_index !== 7'd2 || cyc != 33) begin failures++; $display("FAIL b2b_second got=%h/%h lat=%0d want=00000001/02 lat=33", out_rd_data, out_rd_index, cyc); end
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
